// File: rtl/clock_supervision_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding,
// default timing constants and a small parameter helper.
package clock_supervision_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABILIZE = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRIES   = 4;
   localparam int unsigned LOSS_W            = 8;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; DEPTH must be >= 2.
module bit_sync #(
   parameter int unsigned DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[DEPTH-2:0], i_d};
   end

   assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable synchronized lock, releases the
// downstream reset, and re-sequences on lock loss with bounded retries.
module pll_lock_supervisor
   import clock_supervision_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic              i_refclk,
   input  logic              i_rst,
   input  logic              i_pll_locked,
   output logic              o_pll_rst,
   output logic              o_sys_rst,
   output logic              o_ready,
   output logic              o_fail,
   output logic [LOSS_W-1:0] o_loss_count
);

   localparam int unsigned CNT_W   = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
   localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_e              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [RETRY_W-1:0]  r_retry, w_retry_nxt;
   logic [LOSS_W-1:0]   r_loss, w_loss_nxt;
   logic                r_pll_rst, r_sys_rst, r_ready, r_fail;
   logic                w_locked_s;

   bit_sync #(.DEPTH(2)) u_lock_sync (
      .i_clk (i_refclk),
      .i_rst (i_rst),
      .i_d   (i_pll_locked),
      .o_q   (w_locked_s)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      w_loss_nxt  = r_loss;
      case (r_state)
         ST_PLL_RESET: begin
            if (r_cnt == RST_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            // The cycle lock is first seen is the first of the stable run.
            if (w_locked_s) begin
               w_state_nxt = ST_STABILIZE;
               w_cnt_nxt   = CNT_W'(1);
            end else if (r_cnt == TMO_LAST) begin
               w_cnt_nxt = '0;
               if (r_retry == RETRY_MAX) begin
                  w_state_nxt = ST_FAIL;
               end else begin
                  w_state_nxt = ST_PLL_RESET;
                  w_retry_nxt = r_retry + RETRY_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_STABILIZE: begin
            // Loss takes priority so a drop on the release cycle never reaches RUN.
            if (!w_locked_s) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= STB_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = ST_PLL_RESET;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
               if (r_loss != '1) w_loss_nxt = r_loss + LOSS_W'(1);
            end
         end
         ST_FAIL: ;
         default: begin
            w_state_nxt = ST_PLL_RESET;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they change with the state.
   always_ff @(posedge i_refclk) begin
      if (i_rst) begin
         r_state   <= ST_PLL_RESET;
         r_cnt     <= '0;
         r_retry   <= '0;
         r_loss    <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_retry   <= w_retry_nxt;
         r_loss    <= w_loss_nxt;
         r_pll_rst <= (w_state_nxt == ST_PLL_RESET) || (w_state_nxt == ST_FAIL);
         r_sys_rst <= (w_state_nxt != ST_RUN);
         r_ready   <= (w_state_nxt == ST_RUN);
         r_fail    <= (w_state_nxt == ST_FAIL);
      end
   end

   assign o_pll_rst    = r_pll_rst;
   assign o_sys_rst    = r_sys_rst;
   assign o_ready      = r_ready;
   assign o_fail       = r_fail;
   assign o_loss_count = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: expectations are queued with a target
// cycle when stimulus is applied and checked by a monitor after that edge.
module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       rst;
   logic       locked;
   logic       pll_rst, sys_rst, ready, fail;
   logic [7:0] loss;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      string       tag;
      logic [11:0] exp;
   } exp_t;

   exp_t sbq[$];

   pll_lock_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (20),
      .STABLE_CYCLES (8),
      .MAX_RETRIES   (2)
   ) dut (
      .i_refclk     (clk),
      .i_rst        (rst),
      .i_pll_locked (locked),
      .o_pll_rst    (pll_rst),
      .o_sys_rst    (sys_rst),
      .o_ready      (ready),
      .o_fail       (fail),
      .o_loss_count (loss)
   );

   always #5 clk = ~clk;

   // Monitor: after each rising edge compare every expectation due now.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc <= cyc) begin
            logic [11:0] obs;
            obs = {pll_rst, sys_rst, ready, fail, loss};
            checks++;
            assert (obs === sbq[i].exp && sbq[i].cyc == cyc) else begin
               errors++;
               $error("FAIL %s @cyc %0d: observed {pll_rst,sys_rst,ready,fail,loss}=%03h expected=%03h",
                      sbq[i].tag, cyc, obs, sbq[i].exp);
            end
            sbq.delete(i);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ex(input int d, input string tag, input logic pr, input logic sr,
                     input logic rd, input logic fl, input logic [7:0] lc);
      exp_t e;
      e.cyc = cyc + d;
      e.tag = tag;
      e.exp = {pr, sr, rd, fl, lc};
      sbq.push_back(e);
   endtask

   initial begin
      rst    = 1'b1;
      locked = 1'b0;
      run(3);

      // Reset values, then the first pll_rst pulse and lock acquisition.
      ex(1, "reset_state", 1, 1, 0, 0, 8'd0);
      run(1);
      rst = 1'b0;
      ex(3, "prst_last_cycle", 1, 1, 0, 0, 8'd0);
      ex(4, "prst_released", 0, 1, 0, 0, 8'd0);
      run(9);
      locked = 1'b1;
      ex(9,  "lock_ready_minus1", 0, 1, 0, 0, 8'd0);
      ex(10, "lock_ready", 0, 0, 1, 0, 8'd0);
      run(12);

      // One-cycle lock drop in RUN.
      locked = 1'b0;
      ex(2,  "drop_still_run", 0, 0, 1, 0, 8'd0);
      ex(3,  "drop_detected", 1, 1, 0, 0, 8'd1);
      ex(6,  "drop_pulse_end", 1, 1, 0, 0, 8'd1);
      ex(7,  "drop_pulse_done", 0, 1, 0, 0, 8'd1);
      ex(14, "drop_relock_pre", 0, 1, 0, 0, 8'd1);
      ex(15, "drop_relock_run", 0, 0, 1, 0, 8'd1);
      run(1);
      locked = 1'b1;
      run(16);

      // Glitch while stabilizing at count 5 restarts the stable count.
      locked = 1'b0;
      ex(3, "glitch_setup_loss", 1, 1, 0, 0, 8'd2);
      run(10);
      locked = 1'b1;
      ex(10, "glitch_no_early_run", 0, 1, 0, 0, 8'd2);
      ex(15, "glitch_run_minus1", 0, 1, 0, 0, 8'd2);
      ex(16, "glitch_run", 0, 0, 1, 0, 8'd2);
      run(5);
      locked = 1'b0;
      run(1);
      locked = 1'b1;
      run(12);

      // Permanent loss: three pulses, 20-cycle waits, then FAIL.
      locked = 1'b0;
      for (int p = 0; p < 3; p++) begin
         ex(3 + 24*p,  "retry_pulse_start", 1, 1, 0, 0, 8'd3);
         ex(6 + 24*p,  "retry_pulse_last", 1, 1, 0, 0, 8'd3);
         ex(7 + 24*p,  "retry_wait_start", 0, 1, 0, 0, 8'd3);
         ex(26 + 24*p, "retry_wait_last", 0, 1, 0, 0, 8'd3);
      end
      ex(75,  "fail_enter", 1, 1, 0, 1, 8'd3);
      ex(100, "fail_hold", 1, 1, 0, 1, 8'd3);
      run(102);

      // Reset out of FAIL, normal sequence resumes.
      rst    = 1'b1;
      locked = 1'b1;
      ex(1,  "rst_in_fail", 1, 1, 0, 0, 8'd0);
      ex(4,  "rst_fail_pulse_last", 1, 1, 0, 0, 8'd0);
      ex(5,  "rst_fail_pulse_done", 0, 1, 0, 0, 8'd0);
      ex(12, "rst_fail_run_minus1", 0, 1, 0, 0, 8'd0);
      ex(13, "rst_fail_run", 0, 0, 1, 0, 8'd0);
      run(1);
      rst = 1'b0;
      run(15);

      // Reset out of RUN.
      rst = 1'b1;
      ex(1,  "rst_in_run", 1, 1, 0, 0, 8'd0);
      ex(5,  "rst_run_pulse_done", 0, 1, 0, 0, 8'd0);
      ex(13, "rst_run_ready", 0, 0, 1, 0, 8'd0);
      run(1);
      rst = 1'b0;
      run(15);

      // 300 lock losses: loss_count saturates at 255.
      for (int i = 1; i <= 300; i++) begin
         locked = 1'b0;
         ex(3, "loss_count", 1, 1, 0, 0, (i > 255) ? 8'd255 : 8'(i));
         run(1);
         locked = 1'b1;
         run(15);
      end
      ex(1, "loss_saturated_run", 0, 0, 1, 0, 8'd255);
      run(3);

      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 16, cycles pll_rst is held per PLL reset pulse.
REQ-002 Parameter LOCK_TIMEOUT, default 50000, max cycles to wait for synchronized lock after a reset pulse.
REQ-003 Parameter STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 4, lock-timeout retries allowed before FAIL.
REQ-005 refclk  input  1  sole clock, 50 MHz; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 pll_locked  input  1  PLL locked flag, asynchronous to refclk.
REQ-008 pll_rst  output  1  reset request to the PLL rst input, active-high.
REQ-009 sys_rst  output  1  downstream (codec configuration) reset, active-high, registered.
REQ-010 ready  output  1  high only in RUN.
REQ-011 fail  output  1  high only in FAIL.
REQ-012 loss_count  output  8  saturating count of lock losses seen in RUN.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before use; no other path may read pll_locked.
REQ-014 FSM states SHALL be PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAIL.
REQ-015 PLL_RESET: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with cycle counter cleared.
REQ-016 WAIT_LOCK: locked_s=1 -> STABILIZE; counter reaching LOCK_TIMEOUT with locked_s=0 -> retry_cnt+1 and PLL_RESET, or FAIL if retry_cnt already equals MAX_RETRIES.
REQ-017 STABILIZE: counter counts consecutive locked_s=1 cycles; any locked_s=0 -> WAIT_LOCK with counter cleared (timeout restarts); count reaching STABLE_CYCLES -> RUN.
REQ-018 RUN: locked_s=0 -> PLL_RESET, loss_count+1 (saturating at 255), retry_cnt cleared.
REQ-019 FAIL: terminal; leaves only on rst; pll_rst=1 held, sys_rst=1, fail=1.
REQ-020 sys_rst SHALL be 0 only in RUN; it deasserts the cycle RUN is entered and asserts the cycle after locked_s falls in RUN.
REQ-021 pll_rst SHALL be 1 in PLL_RESET and FAIL, else 0.
REQ-022 retry_cnt SHALL clear on entering RUN.
REQ-023 Counter width SHALL be clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES plus 1; no wrap permitted.
REQ-024 Lock loss coincident with the STABILIZE->RUN transition cycle SHALL take the STABILIZE branch (back to WAIT_LOCK), not count as a RUN loss.

Reset
REQ-025 On rst=1: state=PLL_RESET, counters=0, retry_cnt=0, loss_count=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, fail=0.
REQ-026 rst asserted in any state, including mid-RUN or FAIL, SHALL apply REQ-025 on the next edge; first RST_CYCLES count starts the cycle after rst falls.

Structure
REQ-027 State enumeration and default parameter constants SHALL live in a shared package clock_supervision_pkg.
REQ-028 The synchronizer SHALL be a sub-module bit_sync (2-flop, parameterizable depth, reset value 0); the FSM and counters stay in pll_lock_supervisor.

Verification (bench params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-029 Release rst, raise pll_locked at cycle 10 -> pll_rst high cycles 1-4, sys_rst falls and ready rises exactly 2+8 cycles after pll_locked rises.
REQ-030 Hold pll_locked=0 -> three PLL_RESET pulses of 4 cycles separated by 20 cycles of WAIT_LOCK, then fail=1, pll_rst=1 permanently.
REQ-031 In RUN drop pll_locked for 1 cycle -> sys_rst=1 and ready=0 3 cycles later, loss_count=1, new 4-cycle pll_rst pulse.
REQ-032 Glitch pll_locked low at STABILIZE count 5 -> returns to WAIT_LOCK, ready delayed a full 8 locked cycles after re-lock.
REQ-033 Force 300 lock losses -> loss_count saturates at 255.
REQ-034 Assert rst while in FAIL and in RUN -> all outputs at REQ-025 values next cycle, normal sequence resumes.
